ag_tcu_uop_sequencer: RTL and testbench

Issue-side producer for the AG-TCU execute interface. It takes one WMMA instruction per handshake and expands it into M_STEPS*N_STEPS*K_STEPS micro-ops. Each micro-op is tagged with its step coordinates (m,n,k) and start/end-of-op flags.
Sits between dispatch and the TCU datapath. The datapath is the receiver of this stream and uses step_k plus sop/eop to drive its accumulation.

---
 rtl/ag_tcu_uop_sequencer_pkg.sv | 62 ++++++
 rtl/ag_tcu_uop_sequencer_step_counter.sv | 95 +++++++++
 rtl/ag_tcu_uop_sequencer.sv | 151 +++++++++++++++
 tb/tb_ag_tcu_uop_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ag_tcu_uop_sequencer_pkg.sv
// Shared constants, step-width helper and micro-op types for the AG-TCU
// issue-side micro-op sequencer.
package ag_tcu_uop_sequencer_pkg;

  // Tile geometry at NT=8.
  localparam int AG_TCU_NT      = 8;
  localparam int AG_TCU_M_STEPS = 2;
  localparam int AG_TCU_N_STEPS = 4;
  localparam int AG_TCU_K_STEPS = 4;
  localparam int AG_TCU_UOPS    = AG_TCU_M_STEPS * AG_TCU_N_STEPS * AG_TCU_K_STEPS;

  // Instruction field widths.
  localparam int AG_TCU_WID_BITS  = 2;
  localparam int AG_TCU_PC_BITS   = 32;
  localparam int AG_TCU_UUID_BITS = 44;
  localparam int AG_TCU_FMT_BITS  = 4;

  // Element format identifiers carried in fmt_s / fmt_d.
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_FP32_ID = 4'd0;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_FP16_ID = 4'd1;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_BF16_ID = 4'd2;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_FP8_ID  = 4'd3;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_BF8_ID  = 4'd4;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_I32_ID  = 4'd8;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_I8_ID   = 4'd9;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_U8_ID   = 4'd10;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_I4_ID   = 4'd11;
  localparam logic [AG_TCU_FMT_BITS-1:0] AG_TCU_U4_ID   = 4'd12;

  // Counter width for a step dimension; a single-step dimension still
  // needs one bit so the port exists.
  function automatic int step_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int AG_TCU_SMW = step_width(AG_TCU_M_STEPS);
  localparam int AG_TCU_SNW = step_width(AG_TCU_N_STEPS);
  localparam int AG_TCU_SKW = step_width(AG_TCU_K_STEPS);

  // Sequencer control states.
  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

  // One micro-op as seen by the TCU datapath at the default geometry.
  typedef struct packed {
    logic [AG_TCU_WID_BITS-1:0]  wid;
    logic [AG_TCU_PC_BITS-1:0]   pc;
    logic [AG_TCU_UUID_BITS-1:0] uuid;
    logic [AG_TCU_FMT_BITS-1:0]  fmt_s;
    logic [AG_TCU_FMT_BITS-1:0]  fmt_d;
    logic [AG_TCU_SMW-1:0]       step_m;
    logic [AG_TCU_SNW-1:0]       step_n;
    logic [AG_TCU_SKW-1:0]       step_k;
    logic                        sop;
    logic                        eop;
    logic                        sok;
    logic                        eok;
  } ag_tcu_uop_t;

endpackage

// File: rtl/ag_tcu_uop_sequencer_step_counter.sv
// Nested wrapping (m,n,k) step counter. k is the innermost dimension; each
// dimension advances only when every inner dimension sits at its last value.
// A single-step dimension is permanently at its last value and never moves.
module ag_tcu_step_counter
  import ag_tcu_uop_sequencer_pkg::*;
#(
  parameter int M_STEPS = AG_TCU_M_STEPS,
  parameter int N_STEPS = AG_TCU_N_STEPS,
  parameter int K_STEPS = AG_TCU_K_STEPS,
  localparam int SMW = step_width(M_STEPS),
  localparam int SNW = step_width(N_STEPS),
  localparam int SKW = step_width(K_STEPS)
) (
  input  logic           clk,
  input  logic           reset,        // synchronous, active-low
  input  logic           en,           // advance by one micro-op
  input  logic           clr,          // restart at (0,0,0); wins over en
  output logic [SMW-1:0] cnt_m,
  output logic [SNW-1:0] cnt_n,
  output logic [SKW-1:0] cnt_k,
  output logic           first,        // all dimensions at zero
  output logic           last,         // all dimensions at their last value
  output logic           inner_first,  // innermost (k) at zero
  output logic           inner_last    // innermost (k) at its last value
);

  localparam int NDIM = 3;

  // Dimension 0 is k (innermost), 1 is n, 2 is m.
  function automatic int dim_steps(input int d);
    case (d)
      0:       return K_STEPS;
      1:       return N_STEPS;
      default: return M_STEPS;
    endcase
  endfunction

  logic [NDIM-1:0] dim_first;
  logic [NDIM-1:0] dim_last;
  logic [NDIM-1:0] carry;   // carry[d]: dimension d advances this cycle

  assign carry[0] = en;

  genvar gi;
  generate
    for (gi = 0; gi < NDIM; gi++) begin : g_dim
      localparam int STEPS = dim_steps(gi);
      localparam int W     = step_width(STEPS);
      localparam logic [W-1:0] MAX_VAL = W'(STEPS - 1);

      logic [W-1:0] cnt_reg;
      logic [W-1:0] cnt_next;

      assign dim_first[gi] = (cnt_reg == '0);
      assign dim_last[gi]  = (cnt_reg == MAX_VAL);

      if (gi < NDIM - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & dim_last[gi];
      end

      // Next value: clear, hold, or step with wrap at the dimension size.
      always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
          cnt_next = '0;
        end else if (carry[gi]) begin
          cnt_next = dim_last[gi] ? '0 : cnt_reg + 1'b1;
        end
      end

      // Counter register for this dimension.
      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      if (gi == 0) begin : g_out_k
        assign cnt_k = cnt_reg;
      end else if (gi == 1) begin : g_out_n
        assign cnt_n = cnt_reg;
      end else begin : g_out_m
        assign cnt_m = cnt_reg;
      end
    end
  endgenerate

  assign first       = &dim_first;
  assign last        = &dim_last;
  assign inner_first = dim_first[0];
  assign inner_last  = dim_last[0];

endmodule

// File: rtl/ag_tcu_uop_sequencer.sv
// Expands one WMMA instruction into M_STEPS*N_STEPS*K_STEPS micro-ops tagged
// with (m,n,k) step coordinates and op/k-boundary flags. A new instruction
// can be taken on the same cycle the last micro-op of the previous one fires.
module ag_tcu_uop_sequencer
  import ag_tcu_uop_sequencer_pkg::*;
#(
  parameter int M_STEPS   = AG_TCU_M_STEPS,
  parameter int N_STEPS   = AG_TCU_N_STEPS,
  parameter int K_STEPS   = AG_TCU_K_STEPS,
  parameter int WID_BITS  = AG_TCU_WID_BITS,
  parameter int PC_BITS   = AG_TCU_PC_BITS,
  parameter int UUID_BITS = AG_TCU_UUID_BITS,
  localparam int SMW = step_width(M_STEPS),
  localparam int SNW = step_width(N_STEPS),
  localparam int SKW = step_width(K_STEPS)
) (
  input  logic                 clk,
  input  logic                 reset,      // synchronous, active-low

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID_BITS-1:0]  in_wid,
  input  logic [PC_BITS-1:0]   in_pc,
  input  logic [UUID_BITS-1:0] in_uuid,
  input  logic [3:0]           in_fmt_s,
  input  logic [3:0]           in_fmt_d,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID_BITS-1:0]  out_wid,
  output logic [PC_BITS-1:0]   out_pc,
  output logic [UUID_BITS-1:0] out_uuid,
  output logic [3:0]           out_fmt_s,
  output logic [3:0]           out_fmt_d,
  output logic [SMW-1:0]       out_step_m,
  output logic [SNW-1:0]       out_step_n,
  output logic [SKW-1:0]       out_step_k,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 out_sok,
  output logic                 out_eok,

  output logic                 busy
);

  seq_state_e state_reg;
  seq_state_e state_next;

  logic in_fire;
  logic out_fire;

  logic uop_first;
  logic uop_last;
  logic k_first;
  logic k_last;

  logic [WID_BITS-1:0]  wid_reg;
  logic [PC_BITS-1:0]   pc_reg;
  logic [UUID_BITS-1:0] uuid_reg;
  logic [3:0]           fmt_s_reg;
  logic [3:0]           fmt_d_reg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Control: next state and handshake outputs. in_ready opens during ISSUE
  // only on the cycle the final micro-op is accepted, giving zero bubble.
  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    busy       = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready & uop_last;
        if (out_ready && uop_last && !in_valid) begin
          state_next = SEQ_IDLE;
        end
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  // State register; reset abandons any instruction still being expanded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction payload, captured on acceptance and held for every micro-op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wid_reg   <= '0;
      pc_reg    <= '0;
      uuid_reg  <= '0;
      fmt_s_reg <= '0;
      fmt_d_reg <= '0;
    end else if (in_fire) begin
      wid_reg   <= in_wid;
      pc_reg    <= in_pc;
      uuid_reg  <= in_uuid;
      fmt_s_reg <= in_fmt_s;
      fmt_d_reg <= in_fmt_d;
    end
  end

  // Step coordinates advance only on an accepted micro-op, so a stalled
  // micro-op keeps its coordinates and flags; acceptance restarts at (0,0,0).
  ag_tcu_step_counter #(
    .M_STEPS (M_STEPS),
    .N_STEPS (N_STEPS),
    .K_STEPS (K_STEPS)
  ) u_step_counter (
    .clk         (clk),
    .reset       (reset),
    .en          (out_fire),
    .clr         (in_fire),
    .cnt_m       (out_step_m),
    .cnt_n       (out_step_n),
    .cnt_k       (out_step_k),
    .first       (uop_first),
    .last        (uop_last),
    .inner_first (k_first),
    .inner_last  (k_last)
  );

  assign out_wid   = wid_reg;
  assign out_pc    = pc_reg;
  assign out_uuid  = uuid_reg;
  assign out_fmt_s = fmt_s_reg;
  assign out_fmt_d = fmt_d_reg;

  assign out_sop = uop_first;
  assign out_eop = uop_last;
  assign out_sok = k_first;
  assign out_eok = k_last;

endmodule

// File: tb/tb_ag_tcu_uop_sequencer.sv
// Bench for ag_tcu_uop_sequencer: default (2,4,4) geometry plus a (1,1,1)
// instance, randomized payloads and backpressure, checked against a
// micro-op list computed arithmetically from the instruction.
module tb_ag_tcu_uop_sequencer;

  typedef struct packed {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [43:0] uuid;
    logic [3:0]  fmt_s;
    logic [3:0]  fmt_d;
  } instr_s;

  typedef struct packed {
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [43:0] uuid;
    logic [3:0]  fmt_s;
    logic [3:0]  fmt_d;
    logic [1:0]  m;
    logic [1:0]  n;
    logic [1:0]  k;
    logic        sop;
    logic        eop;
    logic        sok;
    logic        eok;
  } exp_uop_t;

  int vectors     = 0;
  int miscompares = 0;

  instr_s   pending_q[$];
  exp_uop_t exp_q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Instance A: default geometry
  logic        a_in_valid, a_in_ready;
  logic [1:0]  a_in_wid;
  logic [31:0] a_in_pc;
  logic [43:0] a_in_uuid;
  logic [3:0]  a_in_fmt_s, a_in_fmt_d;
  logic        a_out_valid, a_out_ready;
  logic [1:0]  a_out_wid;
  logic [31:0] a_out_pc;
  logic [43:0] a_out_uuid;
  logic [3:0]  a_out_fmt_s, a_out_fmt_d;
  logic [0:0]  a_out_step_m;
  logic [1:0]  a_out_step_n, a_out_step_k;
  logic        a_out_sop, a_out_eop, a_out_sok, a_out_eok, a_busy;

  // Instance B: single-step geometry
  logic        b_in_valid, b_in_ready;
  logic [1:0]  b_in_wid;
  logic [31:0] b_in_pc;
  logic [43:0] b_in_uuid;
  logic [3:0]  b_in_fmt_s, b_in_fmt_d;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_out_wid;
  logic [31:0] b_out_pc;
  logic [43:0] b_out_uuid;
  logic [3:0]  b_out_fmt_s, b_out_fmt_d;
  logic [0:0]  b_out_step_m, b_out_step_n, b_out_step_k;
  logic        b_out_sop, b_out_eop, b_out_sok, b_out_eok, b_busy;

  ag_tcu_uop_sequencer dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_wid(a_in_wid),
    .in_pc(a_in_pc), .in_uuid(a_in_uuid), .in_fmt_s(a_in_fmt_s), .in_fmt_d(a_in_fmt_d),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_wid(a_out_wid),
    .out_pc(a_out_pc), .out_uuid(a_out_uuid), .out_fmt_s(a_out_fmt_s),
    .out_fmt_d(a_out_fmt_d), .out_step_m(a_out_step_m), .out_step_n(a_out_step_n),
    .out_step_k(a_out_step_k), .out_sop(a_out_sop), .out_eop(a_out_eop),
    .out_sok(a_out_sok), .out_eok(a_out_eok), .busy(a_busy)
  );

  ag_tcu_uop_sequencer #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_wid(b_in_wid),
    .in_pc(b_in_pc), .in_uuid(b_in_uuid), .in_fmt_s(b_in_fmt_s), .in_fmt_d(b_in_fmt_d),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_wid(b_out_wid),
    .out_pc(b_out_pc), .out_uuid(b_out_uuid), .out_fmt_s(b_out_fmt_s),
    .out_fmt_d(b_out_fmt_d), .out_step_m(b_out_step_m), .out_step_n(b_out_step_n),
    .out_step_k(b_out_step_k), .out_sop(b_out_sop), .out_eop(b_out_eop),
    .out_sok(b_out_sok), .out_eok(b_out_eok), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_s rand_instr(input logic [1:0] wid);
    instr_s r;
    r.wid   = wid;
    r.pc    = $urandom;
    r.uuid  = 44'({$urandom, $urandom});
    r.fmt_s = 4'($urandom_range(15));
    r.fmt_d = 4'($urandom_range(15));
    return r;
  endfunction

  // Reference: micro-op i of an instruction is (m,n,k) = mixed-radix digits of i.
  task automatic push_instr(input instr_s ins, input int ms, input int ns, input int ks);
    exp_uop_t u;
    int total;
    total = ms * ns * ks;
    for (int i = 0; i < total; i++) begin
      u.wid   = ins.wid;
      u.pc    = ins.pc;
      u.uuid  = ins.uuid;
      u.fmt_s = ins.fmt_s;
      u.fmt_d = ins.fmt_d;
      u.k     = 2'(i % ks);
      u.n     = 2'((i / ks) % ns);
      u.m     = 2'(i / (ks * ns));
      u.sop   = (i == 0);
      u.eop   = (i == total - 1);
      u.sok   = ((i % ks) == 0);
      u.eok   = ((i % ks) == ks - 1);
      exp_q.push_back(u);
    end
  endtask

  task automatic drive(input bit use_b, input bit vld, input bit rdy);
    instr_s p;
    p = (pending_q.size() != 0) ? pending_q[0] : rand_instr(2'($urandom_range(3)));
    if (use_b) begin
      b_in_valid = vld; b_out_ready = rdy;
      b_in_wid = p.wid; b_in_pc = p.pc; b_in_uuid = p.uuid;
      b_in_fmt_s = p.fmt_s; b_in_fmt_d = p.fmt_d;
    end else begin
      a_in_valid = vld; a_out_ready = rdy;
      a_in_wid = p.wid; a_in_pc = p.pc; a_in_uuid = p.uuid;
      a_in_fmt_s = p.fmt_s; a_in_fmt_d = p.fmt_d;
    end
  endtask

  task automatic sample(input bit use_b, output logic ov, output logic ir,
                        output logic bz, output exp_uop_t u);
    if (use_b) begin
      ov = b_out_valid; ir = b_in_ready; bz = b_busy;
      u = {b_out_wid, b_out_pc, b_out_uuid, b_out_fmt_s, b_out_fmt_d,
           {1'b0, b_out_step_m}, {1'b0, b_out_step_n}, {1'b0, b_out_step_k},
           b_out_sop, b_out_eop, b_out_sok, b_out_eok};
    end else begin
      ov = a_out_valid; ir = a_in_ready; bz = a_busy;
      u = {a_out_wid, a_out_pc, a_out_uuid, a_out_fmt_s, a_out_fmt_d,
           {1'b0, a_out_step_m}, a_out_step_n, a_out_step_k,
           a_out_sop, a_out_eop, a_out_sok, a_out_eok};
    end
  endtask

  // Drain pending instructions through one instance, cycle by cycle.
  task automatic run(input bit use_b, input int ms, input int ns, input int ks,
                     input int ready_pct, input int max_fires);
    int fires = 0;
    bit done = 0;
    bit stalled_prev = 0;
    bit exp_valid, exp_ready, ordy;
    logic ov, ir, bz;
    exp_uop_t obs_uop, prev_uop, e;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      ordy = ($urandom_range(99) < ready_pct);
      drive(use_b, pending_q.size() != 0, ordy);
      #1;
      sample(use_b, ov, ir, bz, obs_uop);
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid;
      if (exp_valid && ordy && exp_q[0].eop) exp_ready = 1'b1;
      check("out_valid", ov, exp_valid);
      check("busy", bz, exp_valid);
      check("in_ready", ir, exp_ready);
      if (exp_valid && ov) check("uop", obs_uop, exp_q[0]);
      if (stalled_prev && ov) check("stall_hold", obs_uop, prev_uop);
      stalled_prev = ov && !ordy;
      prev_uop = obs_uop;
      if (!exp_valid && pending_q.size() == 0) begin
        done = 1;
      end else begin
        if (exp_valid && ordy) begin
          e = exp_q.pop_front();
          fires++;
          $display("%s uop wid=%0d pc=%h m=%0d n=%0d k=%0d sop=%0b eop=%0b sok=%0b eok=%0b",
                   use_b ? "cfg111" : "cfg244", obs_uop.wid, obs_uop.pc, obs_uop.m,
                   obs_uop.n, obs_uop.k, obs_uop.sop, obs_uop.eop, obs_uop.sok, obs_uop.eok);
        end
        if (pending_q.size() != 0 && exp_ready) begin
          push_instr(pending_q.pop_front(), ms, ns, ks);
        end
        if (max_fires > 0 && fires >= max_fires) done = 1;
      end
    end
    check("timeout", done, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_in_wid = 0; a_in_pc = 0; a_in_uuid = 0;
    a_in_fmt_s = 0; a_in_fmt_d = 0;
    b_in_valid = 0; b_out_ready = 0; b_in_wid = 0; b_in_pc = 0; b_in_uuid = 0;
    b_in_fmt_s = 0; b_in_fmt_d = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_sop", a_out_sop, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    check("rst_b_busy", b_busy, 1'b0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    reset = 1'b1;

    // single instruction, always ready
    pending_q.push_back(rand_instr(2'd0));
    run(0, 2, 4, 4, 100, 0);

    // single instruction, ~50% backpressure
    pending_q.push_back(rand_instr(2'd3));
    run(0, 2, 4, 4, 50, 0);

    // two back-to-back instructions, wid=1 then wid=2
    pending_q.push_back(rand_instr(2'd1));
    pending_q.push_back(rand_instr(2'd2));
    run(0, 2, 4, 4, 100, 0);

    // reset after the 10th accepted micro-op
    pending_q.push_back(rand_instr(2'd1));
    run(0, 2, 4, 4, 100, 10);
    @(negedge clk);
    reset = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_in_ready", a_in_ready, 1'b1);
    exp_q.delete();
    pending_q.delete();
    pending_q.push_back(rand_instr(2'd2));
    run(0, 2, 4, 4, 100, 0);

    // single-step geometry: one micro-op per instruction, back to back
    for (int i = 0; i < 4; i++) pending_q.push_back(rand_instr(2'(i)));
    run(1, 1, 1, 1, 100, 0);
    for (int i = 0; i < 4; i++) pending_q.push_back(rand_instr(2'(3 - i)));
    run(1, 1, 1, 1, 50, 0);

    // two instructions under backpressure, second held while first runs
    pending_q.push_back(rand_instr(2'd3));
    pending_q.push_back(rand_instr(2'd0));
    run(0, 2, 4, 4, 50, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
